// File: rtl/fetch_align_buffer.sv
// Halfword realigner between the 32-bit fetch port and the RVC expander.
// Queues fetch words as halfwords and presents one 16- or 32-bit instruction per handshake.
module fetch_align_buffer #(
  parameter int          DataWidth = 32,
  parameter int          HW_DEPTH  = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] fetch_data,
  input  logic                 fetch_valid,
  output logic                 fetch_ready,
  input  logic                 redirect,
  input  logic [DataWidth-1:0] redirect_pc,
  output logic [15:0]          inst_lsb,
  output logic [15:0]          inst_msb,
  output logic                 inst_compressed,
  output logic [DataWidth-1:0] inst_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready
);

  localparam int CntW = $clog2(HW_DEPTH) + 1;
  localparam int QW   = HW_DEPTH * 16;

  // Packed queue: halfword 0 (bits [15:0]) is always the oldest entry.
  logic [HW_DEPTH-1:0][15:0] q_q, q_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      drop_lo_q, drop_lo_d;
  logic [DataWidth-1:0]      pc_q, pc_d;

  logic                 hw0_rvc, has1, has2;
  logic                 push_fire, pop_fire;
  logic [1:0]           push_n, pop_n;
  logic [CntW-1:0]      base;
  logic [15:0]          push_lo;
  logic [QW-1:0]        shifted, push_mask, push_val;
  logic                 unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc[0];

  assign hw0_rvc = q_q[0][1:0] != 2'b11;
  assign has1    = count_q != '0;
  assign has2    = count_q >= CntW'(2);

  assign inst_valid      = !redirect && ((has1 && hw0_rvc) || has2);
  assign inst_compressed = has1 && hw0_rvc;
  assign inst_lsb        = q_q[0];
  assign inst_msb        = hw0_rvc ? 16'h0000 : q_q[1];
  assign inst_pc         = pc_q;
  assign fetch_ready     = (count_q <= CntW'(HW_DEPTH - 2)) && !redirect;

  assign push_fire = fetch_valid && fetch_ready;
  assign pop_fire  = inst_valid && inst_ready;
  assign push_n    = !push_fire ? 2'd0 : (drop_lo_q ? 2'd1 : 2'd2);
  assign pop_n     = !pop_fire ? 2'd0 : (inst_compressed ? 2'd1 : 2'd2);
  assign push_lo   = drop_lo_q ? fetch_data[31:16] : fetch_data[15:0];

  // Retire popped halfwords first, then land pushed ones right after the survivors.
  assign base      = count_q - CntW'(pop_n);
  assign shifted   = q_q >> {pop_n, 4'b0000};
  assign push_mask = QW'(push_n == 2'd2 ? 32'hFFFF_FFFF :
                         push_n == 2'd1 ? 32'h0000_FFFF : 32'h0000_0000) << {base, 4'b0000};
  assign push_val  = QW'({fetch_data[31:16], push_lo}) << {base, 4'b0000};

  always_comb begin
    q_d       = (shifted & ~push_mask) | (push_val & push_mask);
    count_d   = count_q + CntW'(push_n) - CntW'(pop_n);
    drop_lo_d = drop_lo_q && !push_fire;
    pc_d      = pc_q;
    if (pop_fire) begin
      pc_d = pc_q + (inst_compressed ? DataWidth'(2) : DataWidth'(4));
    end
    if (redirect) begin
      q_d       = q_q;
      count_d   = '0;
      drop_lo_d = redirect_pc[1];
      pc_d      = {redirect_pc[DataWidth-1:1], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= '0;
      count_q   <= '0;
      drop_lo_q <= 1'b0;
      pc_q      <= RESET_PC;
    end else begin
      q_q       <= q_d;
      count_q   <= count_d;
      drop_lo_q <= drop_lo_d;
      pc_q      <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: hand-computed instruction stream per fetch pattern.
module tb_fetch_align_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] inst_lsb;
  logic [15:0] inst_msb;
  logic        inst_compressed;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  fetch_align_buffer #(.DataWidth(32), .HW_DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_data      (fetch_data),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_lsb        (inst_lsb),
    .inst_msb        (inst_msb),
    .inst_compressed (inst_compressed),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One line per presented/expected instruction slot.
  task automatic chk_inst(input string tag, input logic v, input logic [15:0] lsb,
                          input logic [15:0] msb, input logic c, input logic [31:0] pc);
    $display("inst %s: valid=%0b lsb=%h msb=%h c=%0b pc=%h", tag, inst_valid, inst_lsb,
             inst_msb, inst_compressed, inst_pc);
    check({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, v});
    check({tag, "_pc"}, inst_pc, pc);
    if (v) begin
      check({tag, "_lsb"}, {16'd0, inst_lsb}, {16'd0, lsb});
      check({tag, "_msb"}, {16'd0, inst_msb}, {16'd0, msb});
      check({tag, "_c"}, {31'd0, inst_compressed}, {31'd0, c});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Redirect cycle also offers a void fetch word and a ready decoder.
  task automatic do_redirect(input logic [31:0] target, input logic [31:0] exp_pc);
    redirect    = 1'b1;
    redirect_pc = target;
    fetch_valid = 1'b1;
    fetch_data  = 32'h1111_1111;
    inst_ready  = 1'b1;
    #1;
    check("redir_frdy", {31'd0, fetch_ready}, 32'd0);
    check("redir_ivalid", {31'd0, inst_valid}, 32'd0);
    tick();
    redirect    = 1'b0;
    fetch_valid = 1'b0;
    inst_ready  = 1'b0;
    #1;
    chk_inst("redir_done", 1'b0, 16'h0, 16'h0, 1'b0, exp_pc);
  endtask

  initial begin
    rst = 1'b1; fetch_data = '0; fetch_valid = 1'b0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;

    @(negedge clk);
    #1;
    check("rst_frdy", {31'd0, fetch_ready}, 32'd1);
    check("rst_lsb", {16'd0, inst_lsb}, 32'd0);
    check("rst_msb", {16'd0, inst_msb}, 32'd0);
    check("rst_c", {31'd0, inst_compressed}, 32'd0);
    chk_inst("rst", 1'b0, 16'h0, 16'h0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();

    // Single 32-bit instruction
    fetch_valid = 1'b1; fetch_data = 32'h00A0_0513;
    #1 check("t2_frdy", {31'd0, fetch_ready}, 32'd1);
    tick();
    fetch_valid = 1'b0; inst_ready = 1'b1;
    #1 chk_inst("t2", 1'b1, 16'h0513, 16'h00A0, 1'b0, 32'h0);
    tick();
    inst_ready = 1'b0;
    #1 chk_inst("t2_after", 1'b0, 16'h0, 16'h0, 1'b0, 32'h4);

    // Two compressed in one word
    do_redirect(32'h0, 32'h0);
    fetch_valid = 1'b1; fetch_data = 32'h4585_4505;
    tick();
    fetch_valid = 1'b0; inst_ready = 1'b1;
    #1 chk_inst("t3_a", 1'b1, 16'h4505, 16'h0000, 1'b1, 32'h0);
    tick();
    #1 chk_inst("t3_b", 1'b1, 16'h4585, 16'h0000, 1'b1, 32'h2);
    tick();
    inst_ready = 1'b0;
    #1 chk_inst("t3_end", 1'b0, 16'h0, 16'h0, 1'b0, 32'h4);

    // 32-bit instruction straddling two words
    do_redirect(32'h0, 32'h0);
    fetch_valid = 1'b1; fetch_data = 32'h0513_4505;
    tick();
    fetch_valid = 1'b0; inst_ready = 1'b1;
    #1 chk_inst("t4_a", 1'b1, 16'h4505, 16'h0000, 1'b1, 32'h0);
    tick();
    #1 chk_inst("t4_wait", 1'b0, 16'h0, 16'h0, 1'b0, 32'h2);
    inst_ready = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h1234_00A0;
    tick();
    fetch_valid = 1'b0; inst_ready = 1'b1;
    #1 chk_inst("t4_b", 1'b1, 16'h0513, 16'h00A0, 1'b0, 32'h2);
    tick();
    #1 chk_inst("t4_c", 1'b1, 16'h1234, 16'h0000, 1'b1, 32'h6);
    tick();
    inst_ready = 1'b0;
    #1 chk_inst("t4_end", 1'b0, 16'h0, 16'h0, 1'b0, 32'h8);

    // Redirect to upper halfword drops the lower half
    do_redirect(32'h102, 32'h102);
    fetch_valid = 1'b1; fetch_data = 32'h4505_FFFF;
    tick();
    fetch_valid = 1'b0; inst_ready = 1'b1;
    #1 chk_inst("t5", 1'b1, 16'h4505, 16'h0000, 1'b1, 32'h102);
    tick();
    inst_ready = 1'b0;
    #1 chk_inst("t5_end", 1'b0, 16'h0, 16'h0, 1'b0, 32'h104);

    // Bit 0 of the target ignored
    do_redirect(32'h203, 32'h202);
    fetch_valid = 1'b1; fetch_data = 32'h0001_BEEF;
    tick();
    fetch_valid = 1'b0;
    #1 chk_inst("t5_odd", 1'b1, 16'h0001, 16'h0000, 1'b1, 32'h202);

    // Backpressure: fill to capacity, hold, then drain with a simultaneous push
    do_redirect(32'h0, 32'h0);
    fetch_valid = 1'b1; fetch_data = 32'h00A0_0513;
    tick();
    fetch_data = 32'h4585_4505;
    #1 check("t6_frdy2", {31'd0, fetch_ready}, 32'd1);
    tick();
    fetch_data = 32'hDEAD_BEEF;
    #1 check("t6_full", {31'd0, fetch_ready}, 32'd0);
    chk_inst("t6_hold0", 1'b1, 16'h0513, 16'h00A0, 1'b0, 32'h0);
    tick();
    fetch_valid = 1'b0;
    #1 chk_inst("t6_hold1", 1'b1, 16'h0513, 16'h00A0, 1'b0, 32'h0);
    inst_ready = 1'b1;
    tick();
    #1 chk_inst("t6_d1", 1'b1, 16'h4505, 16'h0000, 1'b1, 32'h4);
    check("t6_frdy_drain", {31'd0, fetch_ready}, 32'd1);
    fetch_valid = 1'b1; fetch_data = 32'h0001_1234;
    tick();
    fetch_valid = 1'b0;
    #1 chk_inst("t6_d2", 1'b1, 16'h4585, 16'h0000, 1'b1, 32'h6);
    tick();
    #1 chk_inst("t6_d3", 1'b1, 16'h1234, 16'h0000, 1'b1, 32'h8);
    tick();
    #1 chk_inst("t6_d4", 1'b1, 16'h0001, 16'h0000, 1'b1, 32'hA);
    tick();
    inst_ready = 1'b0;
    #1 chk_inst("t6_end", 1'b0, 16'h0, 16'h0, 1'b0, 32'hC);

    // Asynchronous reset mid-operation
    do_redirect(32'h40, 32'h40);
    fetch_valid = 1'b1; fetch_data = 32'h00A0_0513;
    tick();
    fetch_valid = 1'b0;
    #1 chk_inst("t7_pre", 1'b1, 16'h0513, 16'h00A0, 1'b0, 32'h40);
    #2 rst = 1'b1;
    #1 chk_inst("t7_async", 1'b0, 16'h0, 16'h0, 1'b0, 32'h0);
    check("t7_frdy", {31'd0, fetch_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
